trap_filter_cfg: RTL and testbench
==================================

TRAP_FILTER_CFG -- requirements
Module: trap_filter_cfg

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADC_W, 12, input sample width, signed.
- OUT_W, 16, output width, signed.
- ACC_W, 32, internal difference/accumulator width, signed.
- MAX_DEPTH, 64, maximum K+L.
- M_W, 8, multiplier width, unsigned.
- DEF_K, 2, reset value of K.
- DEF_L, 4, reset value of L.
- DEF_M, 0, reset value of M.
- DEF_SHIFT, 4, reset value of SHIFT.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock, rising edge.
- reset, in, 1, synchronous active-low reset.
- in_valid, in, 1, sample offered.
- in_data, in, ADC_W, signed sample.
- in_ready, out, 1, sample accepted when in_valid&&in_ready.
- cfg_load, in, 1, request to apply new config.
- cfg_k, in, clog2(MAX_DEPTH)+1, rise length K.
- cfg_l, in, clog2(MAX_DEPTH)+1, delay L.
- cfg_m, in, M_W, pole-zero gain M.
- cfg_shift, in, 5, arithmetic right shift.
- cfg_err, out, 1, one-cycle pulse on rejected config.
- out_valid, out, 1, output sample strobe.
- out_data, out, OUT_W, signed result.
- out_sat, out, 1, out_data was clamped.
- busy, out, 1, high in FLUSH.
REQ-003 Reset SHALL be the reset input, synchronous, active-low; clock SHALL be clk.

Function
REQ-010 FSM states SHALL be FLUSH and RUN; in_ready=1 only in RUN; busy=1 only in FLUSH.
REQ-011 FLUSH SHALL zero one delay-line entry per cycle for MAX_DEPTH+1 cycles, clear all accumulators and pipeline valids, then go to RUN.
REQ-012 cfg_load in RUN with valid config (K>=1, L>=K, K+L<=MAX_DEPTH) SHALL latch K/L/M/SHIFT and go to FLUSH next cycle.
REQ-013 cfg_load with invalid config SHALL pulse cfg_err for one cycle, keep old config and stay in RUN.
REQ-014 cfg_load in FLUSH SHALL be ignored, with no cfg_err.
REQ-015 If cfg_load and an accepted sample occur in the same cycle, the sample SHALL be processed with the old config before the flush.
REQ-016 For accepted samples x[n] (history before the last flush is zero), the block SHALL compute:
- d[n] = x[n] - x[n-K] - x[n-L] + x[n-K-L]
- p[n] = p[n-1] + d[n]
- r[n] = p[n] + M*d[n]
- s[n] = s[n-1] + r[n]
- y[n] = s[n] >>> SHIFT
REQ-017 The block SHALL update state only on accepted samples; idle cycles SHALL NOT advance the delay line or any accumulator.
REQ-018 Arithmetic SHALL be sign-extended to ACC_W; p and s SHALL wrap in two's complement without saturation.
REQ-019 The output SHALL be y clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], with out_sat=1 on that sample when clamped.
REQ-020 out_valid SHALL rise exactly 5 cycles after each accepted sample, one pulse per sample, in order.
REQ-021 out_data and out_sat SHALL hold their values between out_valid pulses.
REQ-022 Pipeline results in flight when FLUSH starts SHALL be discarded, with no out_valid for them.
REQ-023 The delay line SHALL be a circular buffer of MAX_DEPTH+1 entries; the write pointer SHALL wrap to 0 after MAX_DEPTH, and reads SHALL be at (wp-K), (wp-L), (wp-K-L) modulo MAX_DEPTH+1.

Reset
REQ-030 When reset=0 at a clock edge, the block SHALL apply the DEF_* config, go to FLUSH, and clear the accumulators.
REQ-031 During reset, outputs SHALL be out_valid=0, out_data=0, out_sat=0, cfg_err=0, in_ready=0, busy=1.
REQ-032 Reset asserted mid-operation SHALL discard in-flight samples with no out_valid, and SHALL take priority over cfg_load.
REQ-033 After reset release, in_ready SHALL rise MAX_DEPTH+1 cycles later.

Verification
REQ-040 Impulse test: K=2, L=4, M=0, SHIFT=0, input 1 then zeros -> out_data 1,2,2,2,1,0,0...
REQ-041 Step test: same config, input constant 1 -> out_data 1,3,5,7,8,8,... holding at 8.
REQ-042 Gaps test: insert random in_valid gaps into REQ-041 -> identical out_data sequence, each output exactly 5 cycles after its input.
REQ-043 Saturation test: K=32, L=32, M=255, SHIFT=0, step input 2047 -> out_data clamps at 32767 with out_sat=1; negative step gives -32768 with out_sat=1.
REQ-044 Config test: cfg_load with K=5, L=3 -> cfg_err pulse with old config kept; valid cfg_load -> busy for 65 cycles, in-flight outputs dropped, and the post-flush impulse matches the new config.
REQ-045 Reset test: reset pulse during a stream -> no out_valid for samples in flight, in_ready=0 for 65 cycles, then DEF config behaviour per REQ-040 with SHIFT=4.

Source files
------------

// File: rtl/trap_filter_cfg.sv
// Trapezoidal shaper with pole-zero gain and runtime K/L/M/SHIFT; result 5 cycles after each accepted sample.
// in_ready is low while a reset/reconfig flush zeroes the delay line; the output side has no backpressure.
module trap_filter_cfg #(
  parameter int ADC_W     = 12,
  parameter int OUT_W     = 16,
  parameter int ACC_W     = 32,
  parameter int MAX_DEPTH = 64,
  parameter int M_W       = 8,
  parameter int DEF_K     = 2,
  parameter int DEF_L     = 4,
  parameter int DEF_M     = 0,
  parameter int DEF_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ADC_W-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       cfg_load,
  input  logic [$clog2(MAX_DEPTH):0] cfg_k,
  input  logic [$clog2(MAX_DEPTH):0] cfg_l,
  input  logic [M_W-1:0]             cfg_m,
  input  logic [4:0]                 cfg_shift,
  output logic                       cfg_err,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_sat,
  output logic                       busy
);
  localparam int CW    = $clog2(MAX_DEPTH) + 1;
  localparam int DEPTH = MAX_DEPTH + 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_DEPTH);
  localparam logic [CW-1:0] RING = CW'(DEPTH);
  localparam logic [CW:0]   MAXD = (CW+1)'(MAX_DEPTH);
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

  typedef enum logic {FLUSH, RUN} state_t;
  state_t state;

  logic [CW-1:0]           k_r, l_r, kl_r, wp, fcnt;
  logic [M_W-1:0]          m_r;
  logic [4:0]              sh_r;
  logic signed [ADC_W-1:0] dline [DEPTH];
  logic signed [ACC_W-1:0] x1, xk1, xl1, xkl1, d2, p3, md3, s4, y5;
  logic                    v1, v2, v3, v4, v5;
  logic                    accept, cfg_ok, dl_we;
  logic [CW-1:0]           dl_wa;
  logic signed [ADC_W-1:0] dl_wd;
  logic [CW:0]             cfg_sum;
  logic signed [ACC_W-1:0] m_ext;

  function automatic logic [CW-1:0] ring_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? (a - b) : (a + RING - b);
  endfunction

  function automatic logic signed [ACC_W-1:0] sx(input logic [ADC_W-1:0] v);
    return {{(ACC_W-ADC_W){v[ADC_W-1]}}, v};
  endfunction

  assign in_ready = (state == RUN);
  assign busy     = (state == FLUSH);
  assign accept   = in_valid && in_ready;
  assign cfg_sum  = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_ok   = (cfg_k != '0) && (cfg_l >= cfg_k) && (cfg_sum <= MAXD);
  assign m_ext    = $signed({{(ACC_W-M_W){1'b0}}, m_r});

  // Flush zeroes one slot per cycle; in RUN each accepted sample lands at wp.
  assign dl_we = reset && (busy || accept);
  assign dl_wa = busy ? fcnt : wp;
  assign dl_wd = busy ? '0 : in_data;

  always_ff @(posedge clk) begin
    if (dl_we) dline[dl_wa] <= dl_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FLUSH;
      fcnt    <= '0;
      wp      <= '0;
      k_r     <= CW'(DEF_K);
      l_r     <= CW'(DEF_L);
      kl_r    <= CW'(DEF_K + DEF_L);
      m_r     <= M_W'(DEF_M);
      sh_r    <= 5'(DEF_SHIFT);
      cfg_err <= 1'b0;
      {v1, v2, v3, v4, v5, out_valid} <= '0;
      p3       <= '0;
      s4       <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      cfg_err   <= 1'b0;
      v1        <= accept;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      v5        <= v4;
      out_valid <= v5;
      if (accept) begin
        x1   <= sx(in_data);
        xk1  <= sx(dline[ring_sub(wp, k_r)]);
        xl1  <= sx(dline[ring_sub(wp, l_r)]);
        xkl1 <= sx(dline[ring_sub(wp, kl_r)]);
        wp   <= (wp == LAST) ? '0 : wp + CW'(1);
      end
      if (v1) d2 <= x1 - xk1 - xl1 + xkl1;
      if (v2) begin
        p3  <= p3 + d2;
        md3 <= m_ext * d2;
      end
      if (v3) s4 <= s4 + p3 + md3;
      if (v4) y5 <= s4 >>> sh_r;
      if (v5) begin
        if (y5 > OMAX) begin
          out_data <= OMAX[OUT_W-1:0];
          out_sat  <= 1'b1;
        end else if (y5 < OMIN) begin
          out_data <= OMIN[OUT_W-1:0];
          out_sat  <= 1'b1;
        end else begin
          out_data <= y5[OUT_W-1:0];
          out_sat  <= 1'b0;
        end
      end
      if (state == FLUSH) begin
        fcnt <= fcnt + CW'(1);
        if (fcnt == LAST) state <= RUN;
      end else if (cfg_load) begin
        if (cfg_ok) begin
          k_r   <= cfg_k;
          l_r   <= cfg_l;
          kl_r  <= cfg_sum[CW-1:0];
          m_r   <= cfg_m;
          sh_r  <= cfg_shift;
          state <= FLUSH;
          fcnt  <= '0;
          wp    <= '0;
          // Anything still in the pipe belongs to the old history and is dropped.
          {v1, v2, v3, v4, v5, out_valid} <= '0;
          p3 <= '0;
          s4 <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_trap_filter_cfg.sv
// Bench for trap_filter_cfg: directed streams checked cycle by cycle against a sample-history model.
module tb_trap_filter_cfg;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic        cfg_load;
  logic [6:0]  cfg_k;
  logic [6:0]  cfg_l;
  logic [7:0]  cfg_m;
  logic [4:0]  cfg_shift;
  logic        cfg_err;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  trap_filter_cfg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_shift(cfg_shift),
    .cfg_err(cfg_err), .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int data; int sat; } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t pend[$];
  int   hist[$];
  int   mlog[$];
  int   slog[$];
  int   exp_q[$];
  int   cyc = 1;
  bit   armed = 1'b0;
  bit   m_run = 1'b0;
  int   m_cnt = 0;
  int   mk = 2, ml = 4, mm = 0, msh = 4;
  int   m_err = 0;
  int   mp = 0, ms = 0;
  int   last_d = 0, last_s = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int tap(input int i);
    return (i >= 0) ? hist[i] : 0;
  endfunction

  // Model: filter equations evaluated over the list of samples accepted since the last flush.
  initial begin
    exp_t e;
    int   n, d, r, y;
    bit   ev;
    forever begin
      @(negedge clk);
      if (armed) begin
        ev = (pend.size() > 0) && (pend[0].due == cyc);
        chk("out_valid", int'(out_valid), int'(ev));
        if (ev) begin
          e = pend.pop_front();
          last_d = e.data;
          last_s = e.sat;
          mlog.push_back(last_d);
          slog.push_back(last_s);
        end
        chk("out_data", int'($signed(out_data)), last_d);
        chk("out_sat", int'(out_sat), last_s);
        chk("in_ready", int'(in_ready), int'(m_run));
        chk("busy", int'(busy), int'(!m_run));
        chk("cfg_err", int'(cfg_err), m_err);
      end
      if (!reset) begin
        armed = 1'b1; m_run = 1'b0; m_cnt = 0; m_err = 0;
        mk = 2; ml = 4; mm = 0; msh = 4;
        pend.delete(); hist.delete();
        mp = 0; ms = 0; last_d = 0; last_s = 0;
      end else if (armed) begin
        m_err = 0;
        if (!m_run) begin
          if (m_cnt == 64) m_run = 1'b1;
          m_cnt++;
        end else begin
          if (in_valid) begin
            hist.push_back(int'($signed(in_data)));
            n  = hist.size() - 1;
            d  = hist[n] - tap(n - mk) - tap(n - ml) + tap(n - mk - ml);
            mp = mp + d;
            r  = mp + mm * d;
            ms = ms + r;
            y  = ms >>> msh;
            e.due = cyc + 6;
            if (y > 32767) begin e.data = 32767; e.sat = 1; end
            else if (y < -32768) begin e.data = -32768; e.sat = 1; end
            else begin e.data = y; e.sat = 0; end
            pend.push_back(e);
          end
          if (cfg_load) begin
            if (cfg_k >= 1 && cfg_l >= cfg_k && int'(cfg_k) + int'(cfg_l) <= 64) begin
              mk = int'(cfg_k); ml = int'(cfg_l); mm = int'(cfg_m); msh = int'(cfg_shift);
              m_run = 1'b0; m_cnt = 0;
              pend.delete(); hist.delete();
              mp = 0; ms = 0;
            end else begin
              m_err = 1;
            end
          end
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int x);
    in_valid = 1'b1;
    in_data  = 12'(x);
    step();
    in_valid = 1'b0;
  endtask

  task automatic cfg(input int k, input int l, input int m, input int sh);
    cfg_k = 7'(k); cfg_l = 7'(l); cfg_m = 8'(m); cfg_shift = 5'(sh);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic ready_wait(input string nm);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!in_ready && n < 200);
    chk(nm, n, 65);
  endtask

  task automatic chk_log(input string nm, input int cnt);
    chk({nm, "_count"}, mlog.size(), cnt);
    foreach (exp_q[i]) chk(nm, (i < mlog.size()) ? mlog[i] : -999999, exp_q[i]);
  endtask

  task automatic impulse(input int amp);
    mlog.delete(); slog.delete();
    send(amp);
    repeat (11) send(0);
    idle(8);
  endtask

  task automatic bad_cfg(input string nm, input int k, input int l);
    cfg(k, l, 9, 3);
    chk({nm, "_pulse"}, int'(cfg_err), 1);
    step();
    chk({nm, "_clear"}, int'(cfg_err), 0);
    chk({nm, "_run"}, int'(in_ready), 1);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; cfg_load = 1'b0;
    cfg_k = '0; cfg_l = '0; cfg_m = '0; cfg_shift = '0;
    step();
    chk("rst_busy", int'(busy), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    idle(2);
    reset = 1'b1;
    ready_wait("rst_ready_lat");

    cfg(2, 4, 0, 0);
    ready_wait("cfg_flush_lat");
    impulse(1);
    exp_q = '{1, 2, 2, 2, 1, 0, 0};
    chk_log("impulse", 12);
    chk("impulse_nosat", (slog.size() > 0) ? slog[0] : -1, 0);

    mlog.delete();
    repeat (10) send(1);
    idle(8);
    exp_q = '{1, 3, 5, 7, 8, 8, 8, 8, 8, 8};
    chk_log("step", 10);

    cfg(2, 4, 0, 0);
    ready_wait("gaps_flush_lat");
    mlog.delete();
    for (int i = 0; i < 10; i++) begin
      send(1);
      idle(int'($urandom_range(3, 0)));
    end
    idle(8);
    chk_log("gaps", 10);

    cfg(2, 4, 0, 0);
    ready_wait("bad_flush_lat");
    bad_cfg("bad_l_lt_k", 5, 3);
    bad_cfg("bad_k_zero", 0, 4);
    bad_cfg("bad_sum", 32, 33);
    repeat (63) send(0);
    idle(8);
    impulse(1);
    exp_q = '{1, 2, 2, 2, 1, 0, 0};
    chk_log("old_cfg_wrap", 12);

    mlog.delete();
    send(100); send(-5); send(7);
    in_valid = 1'b1; in_data = 12'd9;
    cfg(3, 5, 1, 1);
    in_valid = 1'b0;
    ready_wait("newcfg_flush_lat");
    chk("flush_drop", mlog.size(), 0);
    impulse(2);
    exp_q = '{2, 3, 4, 3, 3, 1, 0, -1, 0};
    chk_log("newcfg", 12);

    cfg(32, 32, 255, 0);
    ready_wait("sat_flush_lat");
    mlog.delete(); slog.delete();
    repeat (70) send(2047);
    idle(8);
    exp_q = '{32767, 32767};
    chk_log("sat_pos", 70);
    chk("sat_pos_flag", (slog.size() > 0) ? slog[0] : -1, 1);
    cfg(32, 32, 255, 0);
    ready_wait("sat2_flush_lat");
    mlog.delete(); slog.delete();
    repeat (10) send(-2048);
    idle(8);
    exp_q = '{-32768, -32768};
    chk_log("sat_neg", 10);
    chk("sat_neg_flag", (slog.size() > 0) ? slog[0] : -1, 1);

    mlog.delete();
    send(500); send(500); send(500);
    in_valid = 1'b1; in_data = 12'd500;
    cfg_k = 7'd3; cfg_l = 7'd5; cfg_m = 8'd1; cfg_shift = 5'd0; cfg_load = 1'b1;
    reset = 1'b0;
    idle(2);
    reset = 1'b1; cfg_load = 1'b0; in_valid = 1'b0;
    ready_wait("midrst_ready_lat");
    chk("reset_drop", mlog.size(), 0);
    impulse(16);
    exp_q = '{1, 2, 2, 2, 1, 0, 0};
    chk_log("reset_def", 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time %0t, expected to finish earlier", $time);
    $fatal(1);
  end
endmodule
